// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: client request/response bundle plus the spi_master command/status lines.
// Latency: none. This file only declares wires.
// Backpressure: request_ready is driven by the arbiter; spi_busy is driven by spi_master.
interface spi_master_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 7
);
  // client side
  logic [NUM_REQUESTERS-1:0]               request_valid;
  logic [NUM_REQUESTERS-1:0]               request_ready;
  logic [NUM_REQUESTERS-1:0]               request_read_write;
  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] request_address;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    request_data;
  logic [NUM_REQUESTERS*16-1:0]            request_divider;
  logic [NUM_REQUESTERS-1:0]               request_clock_phase;
  logic [NUM_REQUESTERS-1:0]               request_clock_polarity;
  logic [NUM_REQUESTERS-1:0]               response_valid;
  logic [DATA_WIDTH-1:0]                   response_data;
  logic                                    response_error;
  logic [NUM_REQUESTERS-1:0]               grant;
  // spi_master side
  logic                                    spi_enable;
  logic                                    spi_read_write;
  logic [ADDRESS_WIDTH-1:0]                spi_address;
  logic [DATA_WIDTH-1:0]                   spi_data;
  logic [15:0]                             spi_divider;
  logic                                    spi_clock_phase;
  logic                                    spi_clock_polarity;
  logic                                    spi_busy;
  logic [DATA_WIDTH-1:0]                   spi_read_data;

  // arbiter view
  modport master (
    input  request_valid, request_read_write, request_address, request_data,
           request_divider, request_clock_phase, request_clock_polarity,
           spi_busy, spi_read_data,
    output request_ready, response_valid, response_data, response_error, grant,
           spi_enable, spi_read_write, spi_address, spi_data, spi_divider,
           spi_clock_phase, spi_clock_polarity
  );

  // environment view (clients + spi_master)
  modport slave (
    output request_valid, request_read_write, request_address, request_data,
           request_divider, request_clock_phase, request_clock_polarity,
           spi_busy, spi_read_data,
    input  request_ready, response_valid, response_data, response_error, grant,
           spi_enable, spi_read_write, spi_address, spi_data, spi_divider,
           spi_clock_phase, spi_clock_polarity
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one spi_master among NUM_REQUESTERS clients.
// Latency: ready is combinational in IDLE; the response pulse comes one cycle after spi_busy falls (or after the start timeout).
// Backpressure: all clients see ready=0 while a transaction is in flight, while spi_busy is high, or during reset.
module spi_master_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int START_TIMEOUT  = 15
) (
  input logic                  clock,
  input logic                  reset,
  spi_master_arbiter_if.master bus
);
  localparam int N  = NUM_REQUESTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  // count value seen during the last START cycle that is allowed without busy
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RESPOND} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    grant_q;
  logic [N-1:0]    resp_vld_q;
  logic [DW-1:0]   resp_dat_q;
  logic            resp_err_q;
  logic            spi_en_q;
  logic            spi_rw_q;
  logic [AW-1:0]   spi_addr_q;
  logic [DW-1:0]   spi_dat_q;
  logic [15:0]     spi_div_q;
  logic            spi_cpha_q;
  logic            spi_cpol_q;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;
  logic [N-1:0]    ready;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_dat;
  logic [15:0]     sel_div;
  logic            sel_rw;
  logic            sel_cpha;
  logic            sel_cpol;

  // round-robin search: first valid client at or after the pointer, wrapping at N
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!win_vld && bus.request_valid[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // ready only toward the winner, only when idle with spi_master free and not in reset
  always_comb begin
    ready = '0;
    if (!reset && state_q == IDLE && !bus.spi_busy && win_vld) ready[win_idx] = 1'b1;
  end

  // pick the winner's command fields out of the flattened request buses
  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    sel_div  = '0;
    sel_rw   = 1'b0;
    sel_cpha = 1'b0;
    sel_cpol = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        sel_addr = bus.request_address[i*AW +: AW];
        sel_dat  = bus.request_data[i*DW +: DW];
        sel_div  = bus.request_divider[i*16 +: 16];
        sel_rw   = bus.request_read_write[i];
        sel_cpha = bus.request_clock_phase[i];
        sel_cpol = bus.request_clock_polarity[i];
      end
    end
  end

  // transaction sequencer: accept, enable until busy (or timeout), wait done, respond
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      resp_vld_q <= '0;
      resp_dat_q <= '0;
      resp_err_q <= 1'b0;
      spi_en_q   <= 1'b0;
      spi_rw_q   <= 1'b0;
      spi_addr_q <= '0;
      spi_dat_q  <= '0;
      spi_div_q  <= '0;
      spi_cpha_q <= 1'b0;
      spi_cpol_q <= 1'b0;
    end else begin
      resp_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (|(bus.request_valid & ready)) begin
            spi_addr_q <= sel_addr;
            spi_dat_q  <= sel_dat;
            spi_div_q  <= sel_div;
            spi_rw_q   <= sel_rw;
            spi_cpha_q <= sel_cpha;
            spi_cpol_q <= sel_cpol;
            grant_q    <= ready;
            owner_q    <= win_idx;
            cnt_q      <= '0;
            spi_en_q   <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (bus.spi_busy) begin
            spi_en_q <= 1'b0;
            state_q  <= WAIT_DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            // spi_master never started: report the failure to the owner
            spi_en_q   <= 1'b0;
            resp_dat_q <= '0;
            resp_err_q <= 1'b1;
            resp_vld_q <= grant_q;
            state_q    <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.spi_busy) begin
            resp_dat_q <= spi_rw_q ? bus.spi_read_data : '0;
            resp_err_q <= 1'b0;
            resp_vld_q <= grant_q;
            state_q    <= RESPOND;
          end
        end
        RESPOND: begin
          // the client just served becomes lowest priority
          ptr_q   <= (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.request_ready      = ready;
  assign bus.response_valid     = resp_vld_q;
  assign bus.response_data      = resp_dat_q;
  assign bus.response_error     = resp_err_q;
  assign bus.grant              = grant_q;
  assign bus.spi_enable         = spi_en_q;
  assign bus.spi_read_write     = spi_rw_q;
  assign bus.spi_address        = spi_addr_q;
  assign bus.spi_data           = spi_dat_q;
  assign bus.spi_divider        = spi_div_q;
  assign bus.spi_clock_phase    = spi_cpha_q;
  assign bus.spi_clock_polarity = spi_cpol_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: randomized client/spi_master stimulus against a transaction-level round-robin model.
// Latency: each transaction is followed from request to response with bounded waits.
// Backpressure: ready is expected low for the whole time a transaction is in flight.
module tb_spi_master_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int TO = 15;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;

  logic [AW-1:0] f_addr[N];
  logic [DW-1:0] f_data[N];
  logic [15:0]   f_div[N];
  logic          f_rw[N];
  logic          f_cpha[N];
  logic          f_cpol[N];

  spi_master_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  spi_master_arbiter #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .START_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // first valid client at or after p, wrapping modulo N
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic apply_fields();
    for (int i = 0; i < N; i++) begin
      bus.request_address[i*AW +: AW]   = f_addr[i];
      bus.request_data[i*DW +: DW]      = f_data[i];
      bus.request_divider[i*16 +: 16]   = f_div[i];
      bus.request_read_write[i]         = f_rw[i];
      bus.request_clock_phase[i]        = f_cpha[i];
      bus.request_clock_polarity[i]     = f_cpol[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      f_addr[i] = AW'($urandom);
      f_data[i] = DW'($urandom);
      f_div[i]  = 16'($urandom);
      f_rw[i]   = 1'($urandom);
      f_cpha[i] = 1'($urandom);
      f_cpol[i] = 1'($urandom);
    end
    apply_fields();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"},    32'(bus.grant), 32'd0);
    check({tag, "_ready"},    32'(bus.request_ready), 32'd0);
    check({tag, "_rsp_vld"},  32'(bus.response_valid), 32'd0);
    check({tag, "_rsp_dat"},  32'(bus.response_data), 32'd0);
    check({tag, "_rsp_err"},  32'(bus.response_error), 32'd0);
    check({tag, "_enable"},   32'(bus.spi_enable), 32'd0);
    check({tag, "_spi_rw"},   32'(bus.spi_read_write), 32'd0);
    check({tag, "_spi_addr"}, 32'(bus.spi_address), 32'd0);
    check({tag, "_spi_dat"},  32'(bus.spi_data), 32'd0);
    check({tag, "_spi_div"},  32'(bus.spi_divider), 32'd0);
    check({tag, "_spi_cph"},  32'(bus.spi_clock_phase), 32'd0);
    check({tag, "_spi_cpl"},  32'(bus.spi_clock_polarity), 32'd0);
  endtask

  // One full transaction. Entered and left one time unit after a rising edge.
  // no_busy: spi_master never raises busy (start timeout). bdelay: enable cycles
  // before busy rises. blen: busy cycles. rdata: value spi_master returns.
  task automatic run_txn(input logic [N-1:0] vmask, input bit no_busy, input int bdelay,
                         input int blen, input logic [DW-1:0] rdata, output int winner);
    int            exp_w;
    int            en_cnt;
    int            bad_ready;
    int            bad_wait;
    int            lat;
    bit            got;
    logic [N-1:0]  oh;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] e_resp;
    logic [15:0]   e_div;
    logic          e_rw;
    logic          e_cpha;
    logic          e_cpol;

    bus.spi_busy      = 1'b0;
    bus.request_valid = vmask;
    exp_w  = rr_pick(vmask, model_ptr);
    oh     = N'(1) << exp_w;
    e_addr = f_addr[exp_w];
    e_data = f_data[exp_w];
    e_div  = f_div[exp_w];
    e_rw   = f_rw[exp_w];
    e_cpha = f_cpha[exp_w];
    e_cpol = f_cpol[exp_w];

    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (bus.request_ready != '0) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    check("accept_seen", 32'(got), 32'd1);
    check("request_ready", 32'(bus.request_ready), 32'(oh));
    winner = oh_idx(bus.request_ready);

    // accept edge; afterwards the request fields are scrambled
    @(posedge clock); #1;
    rand_fields();
    bad_ready = 0;
    en_cnt    = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!no_busy && c == bdelay) bus.spi_busy = 1'b1;
      @(negedge clock);
      if (c == 1) begin
        check("grant", 32'(bus.grant), 32'(oh));
        check("spi_address", 32'(bus.spi_address), 32'(e_addr));
        check("spi_data", 32'(bus.spi_data), 32'(e_data));
        check("spi_divider", 32'(bus.spi_divider), 32'(e_div));
        check("spi_read_write", 32'(bus.spi_read_write), 32'(e_rw));
        check("spi_cpha", 32'(bus.spi_clock_phase), 32'(e_cpha));
        check("spi_cpol", 32'(bus.spi_clock_polarity), 32'(e_cpol));
      end
      if (bus.request_ready != '0) bad_ready++;
      if (!bus.spi_enable) break;
      en_cnt++;
      @(posedge clock); #1;
    end
    check("enable_cycles", 32'(en_cnt), no_busy ? 32'(TO) : 32'(bdelay));

    if (!no_busy) begin
      bad_wait = 0;
      for (int k = 1; k < blen; k++) begin
        @(posedge clock); #1;
        @(negedge clock);
        if (bus.response_valid != '0 || bus.spi_enable) bad_wait++;
        if (bus.request_ready != '0) bad_ready++;
      end
      check("wait_done_quiet", 32'(bad_wait), 32'd0);
      @(posedge clock); #1;
      bus.spi_busy      = 1'b0;
      bus.spi_read_data = rdata;
      lat = -1;
      for (int t = 0; t < 6; t++) begin
        @(negedge clock);
        if (bus.response_valid != '0) begin
          lat = t;
          break;
        end
        if (bus.request_ready != '0) bad_ready++;
        @(posedge clock); #1;
      end
      check("response_latency", 32'(lat), 32'd1);
    end

    e_resp = (no_busy || !e_rw) ? '0 : rdata;
    check("response_valid", 32'(bus.response_valid), 32'(oh));
    check("response_error", 32'(bus.response_error), 32'(no_busy));
    check("response_data", 32'(bus.response_data), 32'(e_resp));
    check("grant_in_respond", 32'(bus.grant), 32'(oh));
    check("spi_address_hold", 32'(bus.spi_address), 32'(e_addr));
    check("spi_data_hold", 32'(bus.spi_data), 32'(e_data));
    check("ready_in_flight", 32'(bad_ready), 32'd0);
    model_ptr = (exp_w + 1) % N;

    @(posedge clock); #1;
    bus.spi_read_data = DW'($urandom);
    check("response_pulse_end", 32'(bus.response_valid), 32'd0);
    check("grant_idle", 32'(bus.grant), 32'd0);
    check("response_data_hold", 32'(bus.response_data), 32'(e_resp));
    check("response_error_hold", 32'(bus.response_error), 32'(no_busy));
  endtask

  initial begin
    int w;
    int bad;
    int order[6];
    logic [N-1:0] m;
    order = '{0, 1, 2, 3, 0, 1};

    reset             = 1'b1;
    bus.request_valid = '0;
    bus.spi_busy      = 1'b0;
    bus.spi_read_data = '0;
    rand_fields();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // every client requesting continuously: strict rotation
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      run_txn(4'hF, 1'b0, $urandom_range(1, 4), $urandom_range(1, 4), DW'($urandom), w);
      check("rr_order", 32'(w), 32'(order[i]));
    end

    // write from client 2
    rand_fields();
    f_addr[2] = 7'h11; f_data[2] = 8'h5A; f_div[2] = 16'd3; f_rw[2] = 1'b0;
    apply_fields();
    run_txn(4'b0100, 1'b0, 3, 2, 8'hC3, w);
    check("wr_client2", 32'(w), 32'd2);

    // read from client 1 returning 0xA5
    rand_fields();
    f_rw[1] = 1'b1;
    apply_fields();
    run_txn(4'b0010, 1'b0, 2, 3, 8'hA5, w);
    check("rd_client1", 32'(w), 32'd1);

    // client 3 with spi_master never starting, then pointer must be at 0
    rand_fields();
    run_txn(4'b1000, 1'b1, 0, 0, 8'h00, w);
    check("timeout_client3", 32'(w), 32'd3);
    rand_fields();
    run_txn(4'hF, 1'b0, 1, 1, DW'($urandom), w);
    check("ptr_after_timeout", 32'(w), 32'd0);

    // spi_busy high while idle holds every client off
    rand_fields();
    bus.spi_busy      = 1'b1;
    bus.request_valid = 4'b0001;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.request_ready != '0 || bus.spi_enable) bad++;
      @(posedge clock); #1;
    end
    check("busy_idle_hold", 32'(bad), 32'd0);
    run_txn(4'b0001, 1'b0, 2, 2, DW'($urandom), w);
    check("busy_idle_then_accept", 32'(w), 32'd0);

    // random masks, delays and timeouts
    for (int i = 0; i < 24; i++) begin
      rand_fields();
      m = N'($urandom_range(1, (1 << N) - 1));
      run_txn(m, ($urandom_range(0, 4) == 0), $urandom_range(1, 6), $urandom_range(1, 5),
              DW'($urandom), w);
    end

    // reset in the middle of WAIT_DONE
    rand_fields();
    bus.spi_busy      = 1'b0;
    bus.request_valid = 4'b0100;
    @(negedge clock);
    check("mr_ready", 32'(bus.request_ready), 32'h4);
    @(posedge clock); #1;
    bus.spi_busy = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("mr_wait_enable", 32'(bus.spi_enable), 32'd0);
    check("mr_wait_grant", 32'(bus.grant), 32'h4);
    #2;
    reset             = 1'b1;
    bus.spi_busy      = 1'b0;
    bus.request_valid = 4'b1010;
    #1;
    check_zero("mr");
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.response_valid != '0) bad++;
    end
    check("mr_no_response", 32'(bad), 32'd0);
    @(posedge clock); #1;
    reset     = 1'b0;
    model_ptr = 0;
    run_txn(4'b1010, 1'b0, 2, 2, DW'($urandom), w);
    check("mr_first_grant", 32'(w), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master instance among NUM_REQUESTERS independent clients using round-robin arbitration.
- Accepts a complete command per requester (address, data, read/write, divider, mode) and drives the spi_master command inputs.
- Sequences the enable/busy handshake and returns read data or an error to the requester that issued the command.
- Sits between client logic and spi_master. Burst mode is not used; spi_master burst_enable and burst_count are tied to 0 outside this block.

Parameters:
- NUM_REQUESTERS, 4, number of clients (2..8).
- DATA_WIDTH, 8, SPI data width; matches spi_master.
- ADDRESS_WIDTH, 7, SPI address width; matches spi_master.
- START_TIMEOUT, 15, maximum cycles in START waiting for spi_busy to rise before an error is returned.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- request_valid  input  NUM_REQUESTERS  per-client command request.
- request_ready  output  NUM_REQUESTERS  one-hot; command accepted on the edge where valid&ready.
- request_read_write  input  NUM_REQUESTERS  1 = read, 0 = write.
- request_address  input  NUM_REQUESTERS*ADDRESS_WIDTH  flattened; client i at [i*AW +: AW].
- request_data  input  NUM_REQUESTERS*DATA_WIDTH  flattened write data.
- request_divider  input  NUM_REQUESTERS*16  flattened clock divider.
- request_clock_phase  input  NUM_REQUESTERS  per-client CPHA.
- request_clock_polarity  input  NUM_REQUESTERS  per-client CPOL.
- response_valid  output  NUM_REQUESTERS  one-hot, one-cycle completion pulse.
- response_data  output  DATA_WIDTH  read data; valid with response_valid.
- response_error  output  1  start timeout flag; valid with response_valid.
- grant  output  NUM_REQUESTERS  one-hot current owner; 0 when idle.
- spi_enable  output  1  to spi_master enable.
- spi_read_write  output  1  to spi_master read_write.
- spi_address  output  ADDRESS_WIDTH  to spi_master address.
- spi_data  output  DATA_WIDTH  to spi_master data.
- spi_divider  output  16  to spi_master divider.
- spi_clock_phase  output  1  to spi_master clock_phase.
- spi_clock_polarity  output  1  to spi_master clock_polarity.
- spi_busy  input  1  from spi_master busy.
- spi_read_data  input  DATA_WIDTH  from spi_master read_data.

Behaviour:
- Reset (async, immediate): all outputs = 0, state = IDLE, round-robin pointer = 0 (client 0 highest priority), timeout counter = 0.
- States: IDLE, START, WAIT_DONE, RESPOND.
- IDLE arbitration:
  - Search request_valid starting at (pointer) and wrapping modulo N; the first set bit wins.
  - request_ready is combinational: only the winner bit is set, and only when state = IDLE and spi_busy = 0.
- IDLE with spi_busy = 1 (stray or previous transaction not finished): request_ready = 0; stay in IDLE.
- Accept edge:
  - Latch the winner's fields into registers driving spi_*; these stay stable until the next accept.
  - Set grant to the winner, clear the timeout counter, go to START.
- START:
  - spi_enable = 1 and the timeout counter increments each cycle.
  - spi_busy = 1: deassert spi_enable on that edge, go to WAIT_DONE.
  - Counter reaches START_TIMEOUT without busy: go to RESPOND with error = 1, data = 0.
  - spi_enable is therefore high for 1..START_TIMEOUT cycles.
- WAIT_DONE:
  - Wait for spi_busy = 0. On that edge capture spi_read_data for reads (0 for writes), set error = 0, go to RESPOND.
  - No timeout applies in WAIT_DONE.
- RESPOND:
  - response_valid[owner] = 1 for exactly one cycle; response_data and response_error are driven.
  - pointer = (owner + 1) mod N; grant = 0; go to IDLE.
- response_data and response_error hold their values until the next RESPOND.
- Throughput: at least one IDLE cycle between transactions. The same client may hold request_valid continuously; it is re-served only after every other valid client has been served once.
- request_valid dropped before acceptance: no effect, nothing is latched.
- Request fields may change after acceptance without affecting the transaction in flight.
- Reset asserted mid-transaction: spi_enable falls immediately and no response is issued. Clients must reissue.

Test Plan:
- Write from client 2 only (addr 0x11, data 0x5A, div 3) -> request_ready[2] 1 cycle; spi_* = 0x11/0x5A/3/rw 0; spi_enable high until busy rises; response_valid = 0b0100 one cycle; error = 0.
- Read from client 1 with the slave model returning 0xA5 -> response_data = 0xA5, response_valid = 0b0010, response_error = 0.
- All 4 clients valid continuously from reset -> grant order 0,1,2,3,0,1; exactly one response per grant; no client served twice before the others.
- spi_busy forced 0 with client 3 valid -> spi_enable high 15 cycles; response_valid = 0b1000 with response_error = 1 and response_data = 0x00; pointer advances to 0.
- Reset pulsed during WAIT_DONE -> all outputs 0 in the same cycle; no response_valid; after reset the first grant goes to the lowest-index valid client.
- spi_busy held 1 in IDLE with client 0 valid -> request_ready stays 0 until busy falls, then client 0 is accepted on the next edge.
